// File: rtl/gemm_batch_seq.sv
// gemm_batch_seq: GEMM batch sequencer for param/src loading, s_init generation and output buffer drain
module gemm_batch_seq #(
  parameter int SRC_DEPTH = 32,
  parameter int DST_DEPTH = 16,
  parameter int PRM_BANKS = 4,
  parameter int PRM_DEPTH = 8,
  localparam int SAW = $clog2(SRC_DEPTH),
  localparam int DAW = $clog2(DST_DEPTH),
  localparam int PAW = $clog2(PRM_DEPTH),
  localparam int BW = PRM_BANKS > 1 ? $clog2(PRM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 matw,
  input  logic                 run,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic                 s_init,
  input  logic                 s_fin,
  output logic                 dst_valid,
  input  logic                 dst_ready,
  output logic                 src_v,
  output logic [SAW-1:0]       src_a,
  output logic [PRM_BANKS-1:0] prm_v,
  output logic [PAW-1:0]       prm_a,
  output logic                 dst_v,
  output logic [DAW-1:0]       dst_a,
  output logic                 busy,
  output logic                 batch_done,
  output logic                 prm_done,
  output logic                 ovf_err
);
  typedef enum logic {D_IDLE, D_RUN} dstate_e;
  dstate_e        st_q, st_d;
  logic [PAW-1:0] prm_a_q, prm_a_d;
  logic [BW-1:0]  bank_q, bank_d;
  logic [SAW-1:0] sa_q, sa_d;
  logic [DAW-1:0] da_q, da_d;
  logic           prm_done_q, prm_done_d, s_init_q, s_init_d, fin_pend_q, fin_pend_d;
  logic           batch_done_q, batch_done_d, ovf_q, ovf_d;
  logic           acc, last, word_end, bank_end;
  always_comb begin
    src_ready    = matw | (run & ~fin_pend_q);
    acc          = src_valid & src_ready;
    src_v        = acc & ~matw;
    prm_v        = (matw & acc) ? PRM_BANKS'(1) << bank_q : '0;
    prm_a        = prm_a_q;
    src_a        = sa_q;
    dst_a        = da_q;
    s_init       = s_init_q;
    prm_done     = prm_done_q;
    batch_done   = batch_done_q;
    ovf_err      = ovf_q;
    dst_valid    = st_q == D_RUN;
    dst_v        = dst_valid & dst_ready;
    busy         = (|sa_q) | dst_valid | fin_pend_q;
    last         = dst_v & (da_q == DAW'(DST_DEPTH - 1));
    word_end     = &prm_a_q;
    bank_end     = bank_q == BW'(PRM_BANKS - 1);
    prm_a_d      = ~matw ? '0 : acc ? prm_a_q + 1'b1 : prm_a_q;
    bank_d       = ~matw ? '0 : (acc & word_end) ? (bank_end ? '0 : bank_q + 1'b1) : bank_q;
    prm_done_d   = matw & acc & word_end & bank_end;
    sa_d         = ~run ? '0 : src_v ? sa_q + 1'b1 : sa_q;
    s_init_d     = src_v & (&sa_q);
    batch_done_d = run & last;
    st_d         = ~run ? D_IDLE
                 : (st_q == D_IDLE) ? (s_fin ? D_RUN : D_IDLE)
                 : (last & ~fin_pend_q & ~s_fin) ? D_IDLE : D_RUN;
    da_d         = (~run | last | ~dst_valid) ? '0 : dst_v ? da_q + 1'b1 : da_q;
    fin_pend_d   = ~run ? 1'b0 : last ? fin_pend_q & s_fin : fin_pend_q | (dst_valid & s_fin);
    ovf_d        = ovf_q | (run & s_fin & fin_pend_q & ~last);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q         <= D_IDLE;
      prm_a_q      <= '0;
      bank_q       <= '0;
      sa_q         <= '0;
      da_q         <= '0;
      prm_done_q   <= 1'b0;
      s_init_q     <= 1'b0;
      fin_pend_q   <= 1'b0;
      batch_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      st_q         <= st_d;
      prm_a_q      <= prm_a_d;
      bank_q       <= bank_d;
      sa_q         <= sa_d;
      da_q         <= da_d;
      prm_done_q   <= prm_done_d;
      s_init_q     <= s_init_d;
      fin_pend_q   <= fin_pend_d;
      batch_done_q <= batch_done_d;
      ovf_q        <= ovf_d;
    end
  end
endmodule

// File: tb/tb_gemm_batch_seq.sv
// tb_gemm_batch_seq: directed and randomized checks of gemm_batch_seq against a job-count model
module tb_gemm_batch_seq;
  localparam int SD = 32, DD = 16, PB = 4, PD = 8;
  logic clk = 0, reset = 0, matw = 0, run = 0, src_valid = 0, s_fin = 0, dst_ready = 0;
  logic src_ready, s_init, dst_valid, src_v, dst_v, busy, batch_done, prm_done, ovf_err;
  logic [4:0] src_a;
  logic [3:0] prm_v, dst_a;
  logic [2:0] prm_a;
  int vectors = 0, miscompares = 0;
  int pk = 0, sa = 0, jobs = 0, sent = 0;
  bit pdone = 0, sinit = 0, bd = 0, ovf = 0;
  int c_prmv, c_pdone, c_srcv, c_sinit, c_dstv, c_bd;
  gemm_batch_seq dut (
    .clk(clk), .reset(reset), .matw(matw), .run(run), .src_valid(src_valid), .src_ready(src_ready),
    .s_init(s_init), .s_fin(s_fin), .dst_valid(dst_valid), .dst_ready(dst_ready), .src_v(src_v),
    .src_a(src_a), .prm_v(prm_v), .prm_a(prm_a), .dst_v(dst_v), .dst_a(dst_a), .busy(busy),
    .batch_done(batch_done), .prm_done(prm_done), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    bit e_srcv;
    #2;
    e_srcv = !matw && run && jobs < 2 && src_valid;
    chk("src_ready", src_ready, matw || (run && jobs < 2));
    chk("src_v", src_v, e_srcv);
    chk("src_a", src_a, sa);
    chk("prm_v", prm_v, (matw && src_valid) ? 32'(1 << (pk / PD)) : 0);
    chk("prm_a", prm_a, pk % PD);
    chk("s_init", s_init, sinit);
    chk("prm_done", prm_done, pdone);
    chk("dst_valid", dst_valid, jobs > 0);
    chk("dst_v", dst_v, jobs > 0 && dst_ready);
    chk("dst_a", dst_a, sent);
    chk("batch_done", batch_done, bd);
    chk("ovf_err", ovf_err, ovf);
    chk("busy", busy, sa != 0 || jobs > 0);
    if (!reset) begin
      pk = 0; sa = 0; jobs = 0; sent = 0; pdone = 0; sinit = 0; bd = 0; ovf = 0;
    end else begin
      pdone = matw && src_valid && pk == PD * PB - 1;
      pk = !matw ? 0 : src_valid ? (pk + 1) % (PD * PB) : pk;
      if (!run) begin
        sa = 0; sinit = 0; jobs = 0; sent = 0; bd = 0;
      end else begin
        sinit = e_srcv && sa == SD - 1;
        if (e_srcv) sa = (sa + 1) % SD;
        bd = 0;
        if (jobs > 0 && dst_ready) begin
          sent++;
          if (sent == DD) begin sent = 0; jobs--; bd = 1; end
        end
        if (s_fin) begin
          if (jobs < 2) jobs++;
          else ovf = 1;
        end
      end
    end
  end
  task automatic step();
    #2;
    c_prmv += int'(prm_v != 0); c_pdone += int'(prm_done); c_srcv += int'(src_v);
    c_sinit += int'(s_init); c_dstv += int'(dst_v); c_bd += int'(batch_done);
    @(negedge clk);
    #1;
  endtask
  task automatic clr();
    c_prmv = 0; c_pdone = 0; c_srcv = 0; c_sinit = 0; c_dstv = 0; c_bd = 0;
  endtask
  task automatic fin();
    s_fin = 1; step(); s_fin = 0;
  endtask
  initial begin
    @(negedge clk); #1;
    step(); step();
    reset = 1;
    clr(); matw = 1; src_valid = 1;
    repeat (32) step();
    matw = 0; src_valid = 0;
    step(); step();
    chk("param_beats", c_prmv, 32);
    chk("param_done_cnt", c_pdone, 1);
    clr(); run = 1;
    for (int i = 0; i < 64; i++) begin src_valid = i[0]; step(); end
    src_valid = 0; step(); step();
    chk("src_beats", c_srcv, 32);
    chk("s_init_cnt", c_sinit, 1);
    clr(); fin();
    for (int i = 0; i < 40; i++) begin dst_ready = ~i[0]; step(); end
    chk("drain_beats", c_dstv, 16);
    chk("drain_done_cnt", c_bd, 1);
    chk("drain_idle", dst_valid, 0);
    clr(); dst_ready = 1; fin();
    repeat (4) step();
    fin();
    chk("pend_src_ready", src_ready, 0);
    repeat (40) step();
    chk("b2b_beats", c_dstv, 32);
    chk("b2b_done_cnt", c_bd, 2);
    dst_ready = 0; fin(); step(); fin(); step(); fin();
    chk("ovf_set", ovf_err, 1);
    run = 0; repeat (3) step();
    chk("ovf_kept_run0", ovf_err, 1);
    reset = 0; step(); reset = 1;
    chk("ovf_cleared", ovf_err, 0);
    clr(); run = 1; dst_ready = 1; fin();
    repeat (7) step();
    run = 0; step();
    chk("abort_dst_valid", dst_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", c_bd, 0);
    for (int s = 0; s < 80; s++) begin
      matw = ($urandom % 5) == 0;
      run = ($urandom % 8) != 0;
      for (int i = 0; i < 40; i++) begin
        src_valid = matw ? ($urandom % 10) != 0 : ($urandom % 10) < 7;
        dst_ready = $urandom % 2;
        s_fin = ($urandom % 10) == 0;
        reset = ($urandom % 300) != 0;
        step();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
